bram_sdp: RTL
=============

# bram_sdp

Simple-dual-port block RAM for the CNN accelerator's feature-map and weight buffers. It has one write port with per-byte enables and one read port with a valid strobe. Read latency and the read/write collision policy are set by parameters. An optional reset-time clear sequencer zeroes the array, so accumulation buffers start at zero without an external initialisation pass.

## Interface
- `W_DATA`, 32: data width in bits; must be a multiple of 8.
- `N_WORD`, 1024: number of words; must satisfy 2 ≤ N_WORD ≤ 2^W_WORD.
- `W_WORD`, 10: address width.
- `RD_LATENCY`, 1: read latency in cycles; legal values are 1 and 2. Value 2 adds an output register.
- `RD_MODE`, 0: collision policy. 0 = read-first (returns the old word); 1 = write-first (returns the new merged word).
- `EN_LOAD_INIT_FILE`, 1'b0: 1 loads `INIT_FILE` with $readmemh at simulation start.
- `INIT_FILE`, "": hex image path.

Ports:
- `clk` input 1: clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `wr_en` input 1: write request.
- `wr_addr` input W_WORD: write word address.
- `wr_be` input W_DATA/8: byte enables; bit i covers data[8i+7:8i].
- `wr_data` input W_DATA: write data.
- `rd_en` input 1: read request.
- `rd_addr` input W_WORD: read word address.
- `rd_data` output W_DATA: read data; holds its value between reads.
- `rd_valid` output 1: one-cycle pulse marking new `rd_data`.
- `busy` output 1: clear sequencer active; all requests are ignored while it is high.

## Operation
- State machine has two states, CLEAR and READY.
  - `rst` forces CLEAR (with the macro) or READY (without), and sets the clear counter to 0.
  - In CLEAR, one word per cycle is written with all-zero data at the counter address. The counter increments each cycle.
  - When the counter reaches N_WORD-1 and that word is written, the state moves to READY.
- A write is accepted when `wr_en` is high, `busy` is low and wr_addr < N_WORD. Only bytes with `wr_be` set are updated. `wr_be` = 0 is a no-op.
- A read is accepted when `rd_en` is high and `busy` is low.
  - rd_addr < N_WORD returns the stored word.
  - rd_addr ≥ N_WORD returns 0 and still asserts `rd_valid`.
- An out-of-range write is dropped silently and changes no location.
- Collision (accepted read and write to the same address in the same cycle):
  - RD_MODE=0 returns the pre-write word.
  - RD_MODE=1 returns the merged word: `wr_data` bytes where `wr_be` is set, old bytes elsewhere.
  - The array always ends up holding the merged word.
- Reads are fully pipelined: one accepted read per cycle, with data returned in order.
- The array itself has no reset. Only control and output registers reset.

## Timing
- Reset values: `rd_data` = 0, `rd_valid` = 0, `busy` = 1 with the macro, 0 without.
- An accepted read in cycle t gives `rd_valid`=1 and `rd_data` = result at the t+RD_LATENCY edge.
- A write in cycle t is visible to a non-colliding read accepted in cycle t+1.
- Clear duration: `busy` stays high for exactly N_WORD cycles after the first cycle with `rst` low, then drops. It does not rise again until the next `rst`.
- `rst` asserted mid-clear restarts the clear from address 0.
- `rst` asserted with reads in flight flushes them: no `rd_valid` pulse is produced for those reads, and `rd_data` is 0.
- `rd_en` or `wr_en` held during `busy` is discarded, not queued.
- Simultaneous `rst` and requests: `rst` wins and the requests are discarded.

## Configuration
- Macro `BRAM_SDP_CLEAR_EN`.
- Defined: the clear sequencer is compiled in, `busy` behaves as described above, and every location reads 0 after the clear completes. This overrides INIT_FILE contents.
- Undefined: no sequencer logic exists and `busy` is tied to 0. The array holds either INIT_FILE contents or X, and requests are accepted in the first cycle after `rst` is released.

## Test plan
- N_WORD=16, macro defined: release `rst`, then read all addresses. Required: `busy` high for 16 cycles, then every `rd_data` = 0 with 16 `rd_valid` pulses.
- RD_LATENCY=2: write 0xA5A5A5A5 to address 3, then read address 3 on the next cycle. Required: `rd_valid` and `rd_data` = 0xA5A5A5A5 exactly 2 edges after the read.
- Byte enables: the word holds 0x11223344; write 0xAABBCCDD with `wr_be`=4'b0101. Required: readback is 0x11BB33DD.
- Collision: the word holds 0x0, then a simultaneous read and write of 0xFFFFFFFF to address 5. Required: RD_MODE=0 returns 0x0, RD_MODE=1 returns 0xFFFFFFFF, and a later read returns 0xFFFFFFFF.
- Pulse `rst` at clear cycle 7, with the macro defined. Required: `busy` stays high for a full 16 cycles after the release and `rd_valid` stays low throughout.
- Back-to-back reads of addresses 0–3 plus a read of address 20 (out of range). Required: 5 consecutive `rd_valid` pulses, in order, with the last `rd_data` = 0. A write to address 20 does not change address 4.

Source files
------------

// File: rtl/bram_sdp.sv
// Simple-dual-port block RAM: byte-enabled write port, pipelined read port, selectable collision policy.
// Define BRAM_SDP_CLEAR_EN to compile in the reset-time clear sequencer that zeroes the array.
module bram_sdp #(
    parameter int    W_DATA            = 32,
    parameter int    N_WORD            = 1024,
    parameter int    W_WORD            = 10,
    parameter int    RD_LATENCY        = 1,
    parameter int    RD_MODE           = 0,
    parameter bit    EN_LOAD_INIT_FILE = 1'b0,
    parameter string INIT_FILE         = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [W_WORD-1:0] wr_addr,
    input  logic [W_DATA/8-1:0] wr_be,
    input  logic [W_DATA-1:0] wr_data,
    input  logic              rd_en,
    input  logic [W_WORD-1:0] rd_addr,
    output logic [W_DATA-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy
);

    localparam int W_BE  = W_DATA / 8;
    localparam int W_IDX = (N_WORD > 1) ? $clog2(N_WORD) : 1;
    localparam logic [W_WORD:0] LIMIT = (W_WORD+1)'(N_WORD);

    logic [W_DATA-1:0] mem [N_WORD];

    logic              clr_we;
    logic [W_IDX-1:0]  clr_idx;

`ifdef BRAM_SDP_CLEAR_EN
    localparam logic [W_WORD-1:0] LAST = W_WORD'(N_WORD - 1);

    typedef enum logic {CLEAR, READY} state_t;
    state_t            state, state_nx;
    logic [W_WORD-1:0] clr_cnt, clr_cnt_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= clr_cnt_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        clr_cnt_nx = clr_cnt;
        if (state == CLEAR) begin
            clr_cnt_nx = clr_cnt + 1'b1;
            if (clr_cnt == LAST)
                state_nx = READY;
        end
    end

    assign busy    = (state == CLEAR);
    assign clr_we  = (state == CLEAR) && !rst;
    assign clr_idx = clr_cnt[W_IDX-1:0];
`else
    assign busy    = 1'b0;
    assign clr_we  = 1'b0;
    assign clr_idx = '0;
`endif

    logic             wr_ok, rd_ok, rd_in_range;
    logic [W_IDX-1:0] wr_idx, rd_idx;
    logic [W_DATA-1:0] rd_word;

    assign wr_ok       = wr_en && !busy && !rst && ({1'b0, wr_addr} < LIMIT);
    assign rd_ok       = rd_en && !busy && !rst;
    assign rd_in_range = ({1'b0, rd_addr} < LIMIT);
    assign wr_idx      = wr_addr[W_IDX-1:0];
    assign rd_idx      = rd_addr[W_IDX-1:0];

    // Write-first collisions forward the incoming bytes over the stored word.
    always_comb begin
        rd_word = mem[rd_idx];
        if (RD_MODE == 1 && wr_ok && (wr_addr == rd_addr)) begin
            for (int i = 0; i < W_BE; i++)
                if (wr_be[i])
                    rd_word[8*i +: 8] = wr_data[8*i +: 8];
        end
        if (!rd_in_range)
            rd_word = '0;
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < W_BE; i++)
                if (wr_be[i])
                    mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    logic              s1_valid;
    logic [W_DATA-1:0] s1_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= rd_ok;
            if (rd_ok)
                s1_data <= rd_word;
        end
    end

    generate
        if (RD_LATENCY == 2) begin : g_lat2
            logic              s2_valid;
            logic [W_DATA-1:0] s2_data;

            always_ff @(posedge clk) begin
                if (rst) begin
                    s2_valid <= 1'b0;
                    s2_data  <= '0;
                end else begin
                    s2_valid <= s1_valid;
                    if (s1_valid)
                        s2_data <= s1_data;
                end
            end

            assign rd_data  = s2_data;
            assign rd_valid = s2_valid;
        end else begin : g_lat1
            assign rd_data  = s1_data;
            assign rd_valid = s1_valid;
        end
    endgenerate

endmodule
